// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM state encoding, baud
// arithmetic helpers, frame constants and the 3-sample majority function.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_ARM   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } rx_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    // Clock cycles per bit period.
    function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // Counter value at the centre of a bit period.
    function automatic int calc_mid(input int bps_cnt);
        return bps_cnt / 2;
    endfunction

    // Majority of three samples; rejects a single-sample glitch.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_recv_if.sv
// Valid/ready byte channel out of the UART receiver.
interface uart_recv_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] uart_data;
    logic                 uart_valid;
    logic                 uart_ready;

    modport master (output uart_data, output uart_valid, input uart_ready);
    modport slave  (input  uart_data, input  uart_valid, output uart_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// Line front end: 2-flop synchroniser, falling-edge detect and a
// 3-sample majority voter (two stored samples plus the live one).
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rxd_i,
    input  logic smp_en_i,
    output logic rxd_s_o,
    output logic fall_o,
    output logic vote_o
);

    logic       meta_q;
    logic       rxd_s_q;
    logic       rxd_d_q;
    logic [1:0] smp_q;

    // Resynchronise the asynchronous line; idle level is high so flops reset to 1.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q  <= 1'b1;
            rxd_s_q <= 1'b1;
            rxd_d_q <= 1'b1;
        end else begin
            meta_q  <= rxd_i;
            rxd_s_q <= meta_q;
            rxd_d_q <= rxd_s_q;
        end
    end

    // Capture the two early votes of a bit (counter at MID-1 and MID).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            smp_q <= 2'b11;
        end else if (smp_en_i) begin
            smp_q <= {smp_q[0], rxd_s_q};
        end else begin
            smp_q <= smp_q;
        end
    end

    assign rxd_s_o = rxd_s_q;
    assign fall_o  = rxd_d_q & ~rxd_s_q;
    // Third vote is the live sample, so the decision is ready at MID+1.
    assign vote_o  = maj3(smp_q[1], smp_q[0], rxd_s_q);

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: arming/idle/start/data/stop FSM with mid-bit majority
// sampling and a one-entry valid/ready holding register.
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        uart_rxd,
    uart_recv_if.master rx_if,
    output logic        uart_rx_busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam int MID     = calc_mid(BPS_CNT);
    localparam int CNT_W   = $clog2(BPS_CNT);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_MID_P1 = CNT_W'(MID + 1);
    localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ovr_q, ovr_d;
    logic                 busy_q;

    logic rxd_s, fall_s, vote_s;
    logic smp_en_s, decide_s, done_s, ferr_s, xfer_s, busy_d;

    uart_rx_sync u_sync (
        .clk_i    (sys_clk),
        .rst_n_i  (sys_rst_n),
        .rxd_i    (uart_rxd),
        .smp_en_i (smp_en_s),
        .rxd_s_o  (rxd_s),
        .fall_o   (fall_s),
        .vote_o   (vote_s)
    );

    assign xfer_s = valid_q & rx_if.uart_ready;

    // Next-state logic: frame sequencing, bit counter and shift register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        smp_en_s  = 1'b0;
        decide_s  = 1'b0;
        done_s    = 1'b0;
        ferr_s    = 1'b0;
        if ((state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP)) begin
            smp_en_s = (cnt_q == CNT_MID_M1) || (cnt_q == CNT_MID);
            decide_s = (cnt_q == CNT_MID_P1);
        end else begin
            smp_en_s = 1'b0;
            decide_s = 1'b0;
        end
        case (state_q)
            ST_ARM: begin
                if (!rxd_s) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (fall_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (decide_s && vote_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (decide_s) begin
                    shreg_d[bit_idx_q] = vote_s;
                end else begin
                    shreg_d = shreg_q;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (decide_s) begin
                    cnt_d = CNT_ZERO;
                    if (vote_s == STOP_LEVEL) begin
                        done_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_d = ST_ARM;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_ARM;
            end
        endcase
        busy_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
    end

    // Holding register: load on completion when empty or draining, else flag overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (done_s) begin
            if (!valid_q || xfer_s) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_ARM;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shreg_q   <= {DATA_BITS{1'b0}};
            data_q    <= {DATA_BITS{1'b0}};
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_s;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_if.uart_data  = data_q;
    assign rx_if.uart_valid = valid_q;
    assign uart_rx_busy     = busy_q;
    assign frame_err        = ferr_q;
    assign overrun          = ovr_q;

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv: the stimulus pushes the bytes the consumer
// should see into a queue, and a monitor pops and compares on every transfer.
module tb_uart_recv;

    localparam int BPS = 434;
    // Line drop -> 2 sync edges -> 1 detection edge -> 9*434+217+2 to valid.
    localparam int LAT_FROM_DRIVE = 3 + 9 * BPS + 217 + 2;

    logic sys_clk;
    logic sys_rst_n;
    logic uart_rxd;
    logic uart_rx_busy;
    logic frame_err;
    logic overrun;
    logic tb_ready;
    logic rnd_rdy;
    logic rand_rdy_en;

    uart_recv_if rx_if ();
    assign rx_if.uart_ready = rand_rdy_en ? rnd_rdy : tb_ready;

    uart_recv #(.CLK_FREQ(50000000), .UART_BPS(115200)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .uart_rxd     (uart_rxd),
        .rx_if        (rx_if),
        .uart_rx_busy (uart_rx_busy),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    int exp_err = 0;
    int exp_ovr = 0;
    int start_cyc = 0;
    int s0 = 0;
    int t0 = 0;
    bit seen = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rb;
    bit bad;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        rnd_rdy = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            rnd_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Monitor: pop and compare on every transfer, tally pulses.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rx_if.uart_valid && rx_if.uart_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected byte: actual=%0h required=none", rx_if.uart_data);
                end else begin
                    chk("rx byte", {24'd0, rx_if.uart_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (frame_err && overrun) begin
                chk("ferr/ovr same cycle", 32'd1, 32'd0);
            end
            if (frame_err) err_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    // Send one 8N1 frame; optionally pulse reset in the middle of data bit rst_bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit push, input int rst_bit);
        if (push) exp_q.push_back(b);
        start_cyc = cyc;
        uart_rxd = 1'b0;
        wait_cyc(BPS);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            if (i == rst_bit) begin
                wait_cyc(200);
                sys_rst_n = 1'b0;
                wait_cyc(3);
                chk("mid reset valid", {31'd0, rx_if.uart_valid}, 32'd0);
                chk("mid reset busy", {31'd0, uart_rx_busy}, 32'd0);
                chk("mid reset data", {24'd0, rx_if.uart_data}, 32'd0);
                sys_rst_n = 1'b1;
                wait_cyc(BPS - 203);
            end else begin
                wait_cyc(BPS);
            end
        end
        uart_rxd = stop;
        wait_cyc(BPS);
        uart_rxd = 1'b1;
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        uart_rxd    = 1'b1;
        tb_ready    = 1'b0;
        rand_rdy_en = 1'b0;
        wait_cyc(5);
        chk("reset valid", {31'd0, rx_if.uart_valid}, 32'd0);
        chk("reset data", {24'd0, rx_if.uart_data}, 32'd0);
        chk("reset busy", {31'd0, uart_rx_busy}, 32'd0);
        chk("reset frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset overrun", {31'd0, overrun}, 32'd0);
        sys_rst_n = 1'b1;

        // 1: basic frame, latency and single-cycle valid
        tb_ready = 1'b1;
        wait_cyc(440);
        fork
            send_frame(8'hA5, 1'b1, 1'b1, -1);
            begin
                @(negedge sys_clk);
                t0 = start_cyc;
                seen = 1'b0;
                for (int i = 0; i < 5000 && !seen; i++) begin
                    @(negedge sys_clk);
                    if (rx_if.uart_valid) seen = 1'b1;
                end
                chk("t1 latency", cyc - t0, LAT_FROM_DRIVE);
                @(negedge sys_clk);
                chk("t1 valid one cycle", {31'd0, rx_if.uart_valid}, 32'd0);
            end
        join
        wait_cyc(10);
        chk("t1 frame_err count", err_cnt, exp_err);
        chk("t1 overrun count", ovr_cnt, exp_ovr);

        // 2: short low glitch on idle is rejected
        uart_rxd = 1'b0;
        wait_cyc(100);
        uart_rxd = 1'b1;
        wait_cyc(440);
        chk("t2 busy after glitch", {31'd0, uart_rx_busy}, 32'd0);
        chk("t2 frame_err count", err_cnt, exp_err);
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        wait_cyc(10);

        // 3: bad stop bit, re-arm, then a good frame
        send_frame(8'h81, 1'b0, 1'b0, -1);
        exp_err++;
        wait_cyc(440);
        chk("t3 frame_err count", err_cnt, exp_err);
        chk("t3 busy", {31'd0, uart_rx_busy}, 32'd0);
        send_frame(8'h7E, 1'b1, 1'b1, -1);
        wait_cyc(10);
        chk("t3 queue drained", exp_q.size(), 32'd0);

        // 4: consumer stalled, second byte overruns
        tb_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        exp_ovr++;
        chk("t4 valid held", {31'd0, rx_if.uart_valid}, 32'd1);
        chk("t4 data held", {24'd0, rx_if.uart_data}, 32'h11);
        chk("t4 overrun count", ovr_cnt, exp_ovr);
        tb_ready = 1'b1;
        wait_cyc(3);
        chk("t4 drained", {31'd0, rx_if.uart_valid}, 32'd0);

        // 5: transfer in the exact cycle the next byte completes
        tb_ready = 1'b0;
        s0 = cyc;
        fork
            begin
                send_frame(8'h55, 1'b1, 1'b1, -1);
                send_frame(8'hAA, 1'b1, 1'b1, -1);
            end
            begin
                wait_cyc(10 * BPS + LAT_FROM_DRIVE - 1);
                tb_ready = 1'b1;
                wait_cyc(1);
                tb_ready = 1'b0;
                wait_cyc(2);
                chk("t5 valid kept", {31'd0, rx_if.uart_valid}, 32'd1);
                chk("t5 data new", {24'd0, rx_if.uart_data}, 32'hAA);
            end
        join
        chk("t5 overrun count", ovr_cnt, exp_ovr);
        tb_ready = 1'b1;
        wait_cyc(3);
        chk("t5 queue drained", exp_q.size(), 32'd0);

        // 6: reset in mid-data while the line is low
        send_frame(8'hF0, 1'b1, 1'b0, 2);
        wait_cyc(20);
        chk("t6 no frame_err", err_cnt, exp_err);
        send_frame(8'h0F, 1'b1, 1'b1, -1);
        wait_cyc(10);
        chk("t6 queue drained", exp_q.size(), 32'd0);

        // random frames with random gaps, random stop errors and random ready
        rand_rdy_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_cyc($urandom_range(0, 30));
            rb  = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(rb, !bad, !bad, -1);
            if (bad) begin
                exp_err++;
                wait_cyc(440);
            end
        end
        wait_cyc(20);
        chk("final queue drained", exp_q.size(), 32'd0);
        chk("final frame_err count", err_cnt, exp_err);
        chk("final overrun count", ovr_cnt, exp_ovr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
